or_gate_response_checker: RTL
=============================

Name: or_gate_response_checker

Overview:
- Self-checking monitor for the two-input OR testbench: the receiving end of the stimulus sweep that drives a, b and observes x.
- Samples the stimulus vector {a,b} and the DUT output x on a clock, checks x == a|b once per stable vector, and tracks coverage of all four input combinations.
- Reports pass/fail, an error count, and a timeout when coverage stalls.
- Sits beside the gate under test in the simulation top, replacing manual waveform inspection.

Parameters:
- HOLD_CYCLES, 2, consecutive rising edges {a,b} must be unchanged before x is checked (min 1).
- CNT_W, 8, width of the error counter.
- TIMEOUT, 64, max cycles between new coverage bits before the run aborts (min 1).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  one-cycle pulse that starts a checking run.
- i_a  input  1  stimulus bit a.
- i_b  input  1  stimulus bit b.
- i_x  input  1  DUT output under check.
- o_busy  output  1  high while a run is active.
- o_done  output  1  high once a run has finished; held until the next start.
- o_pass  output  1  valid when o_done=1: full coverage and zero errors.
- o_timeout  output  1  valid when o_done=1: run aborted by TIMEOUT.
- o_err_pulse  output  1  one-cycle pulse on each mismatch.
- o_err_cnt  output  CNT_W  mismatches this run; saturates at all-ones.
- o_coverage  output  4  bit {b,a} set once that vector has been checked.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (async assert, sync release): state IDLE, all outputs 0, internal counters 0, prev vector 2'b00, checked flag 0.
- States:
  - IDLE: o_busy=0. On i_start=1: clear o_coverage, o_err_cnt, o_done, o_pass, o_timeout; set stab_cnt=0, to_cnt=0, checked=0; go RUN.
  - RUN: o_busy=1.
    - Each edge: if {i_a,i_b} != prev, set prev={i_a,i_b}, stab_cnt=1, checked=0; otherwise stab_cnt increments, saturating at HOLD_CYCLES.
    - Check fires on the edge where the incremented stab_cnt equals HOLD_CYCLES and checked=0. The first RUN edge always counts as a change. With HOLD_CYCLES=1, the check fires on the change edge itself.
    - On check: compare the i_x sampled on that same edge to i_a|i_b; set checked=1; set o_coverage[{i_b,i_a}].
    - On mismatch: o_err_pulse=1 for the next cycle; o_err_cnt+1, saturating.
    - A vector is checked at most once per stable period. Returning to an earlier vector re-arms and re-checks it; coverage stays set and the error counts again on mismatch.
    - to_cnt increments every RUN cycle and resets to 0 when a previously-clear coverage bit is set.
    - When o_coverage becomes 4'b1111, go FIN with o_timeout=0.
    - When to_cnt reaches TIMEOUT, go FIN with o_timeout=1.
    - If both happen on the same edge, coverage wins (o_timeout=0).
  - FIN, one cycle: o_busy=0, o_done=1, o_pass = (coverage==4'b1111) & (err_cnt==0) & ~timeout; go IDLE.
- Results hold in IDLE until the next i_start.
- i_start while in RUN or FIN is ignored.
- i_start on the same edge as FIN's exit is not taken; start is accepted only from IDLE.
- o_err_pulse is registered: one cycle after the checking edge.
- Done latency: o_done rises one cycle after the edge that completes coverage.
- Reset mid-run: immediate return to IDLE, all outputs 0, no result reported.

Test Plan:
- HOLD_CYCLES=2. Start, then drive {a,b} = 00,10,01,11, each held 2 cycles, with x=a|b → o_coverage steps 0001,0011,0111,1111; o_done=1 and o_pass=1 one cycle after the last check; o_err_cnt=0; o_timeout=0.
- Same sweep with x forced to 0 on vector 11 → one o_err_pulse after the 11 check; o_err_cnt=1; o_done=1, o_pass=0.
- Toggle a every cycle (hold 1) with HOLD_CYCLES=2 → no checks, o_coverage=0000; after 64 cycles o_done=1, o_timeout=1, o_pass=0.
- Hold 01 for 10 cycles with wrong x → exactly one error counted; then 00→01 again with wrong x → o_err_cnt=2, o_coverage[2] set once.
- CNT_W=2, repeated wrong vectors (≥5 mismatches) → o_err_cnt saturates at 3.
- Assert rst_n=0 mid-run after 2 vectors are covered → outputs 0 immediately; a new i_start gives a clean run, coverage starting from 0000.

Source files
------------

// File: rtl/or_gate_response_checker.sv
// Response checker for a two-input OR under test: waits for each stimulus vector
// to be stable, checks x == a|b once per stable period, and tracks input coverage.
module or_gate_response_checker #(
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_a,
    input  logic             i_b,
    input  logic             i_x,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic             o_timeout,
    output logic             o_err_pulse,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [3:0]       o_coverage
);
    localparam int STAB_W = $clog2(HOLD_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

    state_e            state_q, state_d;
    logic [1:0]        prev_q, prev_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic              checked_q, checked_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [3:0]        cov_q, cov_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              err_pulse_q, err_pulse_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;

    logic       chg, fire, new_bit;
    logic [1:0] vec, idx;

    assign vec = {i_a, i_b};
    assign idx = {i_b, i_a};

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        stab_d      = stab_q;
        checked_d   = checked_q;
        to_d        = to_q;
        cov_d       = cov_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;
        done_d      = done_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        chg         = 1'b0;
        fire        = 1'b0;
        new_bit     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    cov_d     = 4'b0000;
                    err_cnt_d = '0;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    stab_d    = '0;
                    to_d      = '0;
                    checked_d = 1'b0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                // stab_q == 0 only right after start, so the first RUN edge is a change
                chg = (vec != prev_q) || (stab_q == '0);
                if (chg) begin
                    prev_d    = vec;
                    stab_d    = STAB_W'(1);
                    checked_d = 1'b0;
                end else if (stab_q != STAB_W'(HOLD_CYCLES)) begin
                    stab_d = stab_q + STAB_W'(1);
                end
                fire = (stab_d == STAB_W'(HOLD_CYCLES)) && (chg || !checked_q);
                if (fire) begin
                    checked_d  = 1'b1;
                    new_bit    = !cov_q[idx];
                    cov_d[idx] = 1'b1;
                    if (i_x != (i_a | i_b)) begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                end
                to_d = new_bit ? '0 : to_q + TO_W'(1);
                // Completed coverage takes priority over a simultaneous timeout
                if (cov_d == 4'b1111) begin
                    state_d   = S_FIN;
                    done_d    = 1'b1;
                    timeout_d = 1'b0;
                    pass_d    = (err_cnt_d == '0);
                end else if (to_d == TO_W'(TIMEOUT)) begin
                    state_d   = S_FIN;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            prev_q      <= 2'b00;
            stab_q      <= '0;
            checked_q   <= 1'b0;
            to_q        <= '0;
            cov_q       <= 4'b0000;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            stab_q      <= stab_d;
            checked_q   <= checked_d;
            to_q        <= to_d;
            cov_q       <= cov_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_busy      = (state_q == S_RUN);
    assign o_done      = done_q;
    assign o_pass      = pass_q;
    assign o_timeout   = timeout_q;
    assign o_err_pulse = err_pulse_q;
    assign o_err_cnt   = err_cnt_q;
    assign o_coverage  = cov_q;
endmodule
